hsv_arbiter: RTL and testbench

Shares one hsv pipeline between two independent gradient streams, channel 0 and channel 1. Each channel carries mag/gx/gy.
- Arbitrates inputs round-robin onto the single hsv input port.
- Records the channel ID of every issued beat in an in-order tag FIFO.
- Steers each returning h/v result back to its originating channel.
- Sits between two magnitude modules and one hsv instance. The hsv block is in-order with ready/valid on both sides.

---
 rtl/hsv_arbiter.sv | 131 +++++++++++++
 tb/tb_hsv_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_arbiter.sv
// Two-channel round-robin front end for a shared, in-order hsv unit.
// Issued channel IDs are queued so each result returns to its requester.
module hsv_arbiter #(
   parameter int width_p      = 8,
   parameter int width_grad_p = 8,
   parameter int depth_log2_p = 3
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    req0_valid_i,
   input  logic [width_p-1:0]      req0_mag_i,
   input  logic [width_grad_p-1:0] req0_gx_i,
   input  logic [width_grad_p-1:0] req0_gy_i,
   output logic                    req0_ready_o,
   input  logic                    req1_valid_i,
   input  logic [width_p-1:0]      req1_mag_i,
   input  logic [width_grad_p-1:0] req1_gx_i,
   input  logic [width_grad_p-1:0] req1_gy_i,
   output logic                    req1_ready_o,
   output logic                    hsv_valid_o,
   output logic [width_p-1:0]      hsv_mag_o,
   output logic [width_grad_p-1:0] hsv_gx_o,
   output logic [width_grad_p-1:0] hsv_gy_o,
   input  logic                    hsv_ready_i,
   input  logic                    res_valid_i,
   input  logic [width_p-1:0]      res_h_i,
   input  logic [width_p-1:0]      res_v_i,
   output logic                    res_ready_o,
   output logic                    out0_valid_o,
   output logic [width_p-1:0]      out0_h_o,
   output logic [width_p-1:0]      out0_v_o,
   input  logic                    out0_ready_i,
   output logic                    out1_valid_o,
   output logic [width_p-1:0]      out1_h_o,
   output logic [width_p-1:0]      out1_v_o,
   input  logic                    out1_ready_i
);

   localparam int depth_lp = 1 << depth_log2_p;
   localparam logic [depth_log2_p:0] full_c = {1'b1, {depth_log2_p{1'b0}}};

   logic                    last_q, last_d;
   logic                    lock_q, lock_d;
   logic                    lid_q, lid_d;
   logic                    blk_q;
   logic [depth_log2_p-1:0] wptr_q, wptr_d;
   logic [depth_log2_p-1:0] rptr_q, rptr_d;
   logic [depth_log2_p:0]   cnt_q, cnt_d;
   logic [depth_lp-1:0]     tag_q;

   logic gate, full, grant, vg, fire, pop, nempty, head;

   // Outputs are held quiet during reset and for one cycle after it.
   assign gate   = reset_i | blk_q;
   assign full   = (cnt_q == full_c);
   assign nempty = (cnt_q != '0);
   assign head   = tag_q[rptr_q];

   always_comb begin
      grant = req1_valid_i;
      if (lock_q) begin
         grant = lid_q;
      end else if (req0_valid_i && req1_valid_i) begin
         grant = ~last_q;
      end
   end

   assign vg           = grant ? req1_valid_i : req0_valid_i;
   assign hsv_valid_o  = vg & ~full & ~gate;
   assign hsv_mag_o    = grant ? req1_mag_i : req0_mag_i;
   assign hsv_gx_o     = grant ? req1_gx_i : req0_gx_i;
   assign hsv_gy_o     = grant ? req1_gy_i : req0_gy_i;
   assign req0_ready_o = ~grant & hsv_ready_i & ~full & ~gate;
   assign req1_ready_o = grant & hsv_ready_i & ~full & ~gate;
   assign fire         = hsv_valid_o & hsv_ready_i;

   assign res_ready_o  = nempty & ~gate &
                         (head ? out1_ready_i : out0_ready_i);
   assign out0_valid_o = res_valid_i & nempty & ~head & ~gate;
   assign out1_valid_o = res_valid_i & nempty & head & ~gate;
   assign out0_h_o     = res_h_i;
   assign out0_v_o     = res_v_i;
   assign out1_h_o     = res_h_i;
   assign out1_v_o     = res_v_i;
   assign pop          = res_valid_i & res_ready_o;

   always_comb begin
      last_d = last_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      lock_d = hsv_valid_o & ~hsv_ready_i;
      lid_d  = lock_d ? grant : lid_q;
      if (fire) begin
         last_d = grant;
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (fire && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !fire) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      blk_q <= reset_i;
      if (reset_i) begin
         last_q <= 1'b1;
         lock_q <= 1'b0;
         lid_q  <= 1'b0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         tag_q  <= '0;
      end else begin
         last_q <= last_d;
         lock_q <= lock_d;
         lid_q  <= lid_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (fire) begin
            tag_q[wptr_q] <= grant;
         end
      end
   end

endmodule

// File: tb/tb_hsv_arbiter.sv
// Bench for hsv_arbiter: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_hsv_arbiter;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       req0_valid_i, req1_valid_i;
   logic [7:0] req0_mag_i, req0_gx_i, req0_gy_i;
   logic [7:0] req1_mag_i, req1_gx_i, req1_gy_i;
   logic       req0_ready_o, req1_ready_o;
   logic       hsv_valid_o, hsv_ready_i;
   logic [7:0] hsv_mag_o, hsv_gx_o, hsv_gy_o;
   logic       res_valid_i, res_ready_o;
   logic [7:0] res_h_i, res_v_i;
   logic       out0_valid_o, out0_ready_i;
   logic       out1_valid_o, out1_ready_i;
   logic [7:0] out0_h_o, out0_v_o, out1_h_o, out1_v_o;

   always #5 clk_i = ~clk_i;

   hsv_arbiter #(.width_p(8), .width_grad_p(8), .depth_log2_p(3)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .req0_valid_i(req0_valid_i), .req0_mag_i(req0_mag_i),
      .req0_gx_i(req0_gx_i), .req0_gy_i(req0_gy_i),
      .req0_ready_o(req0_ready_o),
      .req1_valid_i(req1_valid_i), .req1_mag_i(req1_mag_i),
      .req1_gx_i(req1_gx_i), .req1_gy_i(req1_gy_i),
      .req1_ready_o(req1_ready_o),
      .hsv_valid_o(hsv_valid_o), .hsv_mag_o(hsv_mag_o),
      .hsv_gx_o(hsv_gx_o), .hsv_gy_o(hsv_gy_o),
      .hsv_ready_i(hsv_ready_i),
      .res_valid_i(res_valid_i), .res_h_i(res_h_i), .res_v_i(res_v_i),
      .res_ready_o(res_ready_o),
      .out0_valid_o(out0_valid_o), .out0_h_o(out0_h_o),
      .out0_v_o(out0_v_o), .out0_ready_i(out0_ready_i),
      .out1_valid_o(out1_valid_o), .out1_h_o(out1_h_o),
      .out1_v_o(out1_v_o), .out1_ready_i(out1_ready_i)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: queue of outstanding channel IDs plus arbitration state.
   int q[$];
   int m_last = 1;
   int m_lock = 0;
   int m_lid  = 0;
   int m_blk  = 0;

   typedef struct {
      int g, any, hv, r0, r1, rr, ov0, ov1;
   } exp_t;

   typedef struct {
      int rst, v0, v1, hr, rv, o0r, o1r, m0, m1;
      int hv, r0, r1, rr, ov0, ov1, mag;
   } vec_t;

   vec_t vt[12];

   function automatic int b(input logic x);
      return (x === 1'b1) ? 1 : 0;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t m_eval();
      exp_t e;
      int gate, full, vg, ne, head;
      gate = b(reset_i) | m_blk;
      if (m_lock != 0) e.g = m_lid;
      else if (b(req0_valid_i) && b(req1_valid_i)) e.g = 1 - m_last;
      else e.g = b(req1_valid_i);
      e.any = m_lock | b(req0_valid_i) | b(req1_valid_i);
      full = (q.size() == 8) ? 1 : 0;
      vg = (e.g == 1) ? b(req1_valid_i) : b(req0_valid_i);
      e.hv = (gate == 0 && vg == 1 && full == 0) ? 1 : 0;
      e.r0 = (gate == 0 && e.g == 0 && b(hsv_ready_i) == 1 && full == 0) ? 1 : 0;
      e.r1 = (gate == 0 && e.g == 1 && b(hsv_ready_i) == 1 && full == 0) ? 1 : 0;
      ne = (q.size() != 0) ? 1 : 0;
      head = (ne == 1) ? q[0] : 0;
      e.rr = (gate == 0 && ne == 1 &&
              ((head == 1) ? b(out1_ready_i) : b(out0_ready_i)) == 1) ? 1 : 0;
      e.ov0 = (gate == 0 && b(res_valid_i) == 1 && ne == 1 && head == 0) ? 1 : 0;
      e.ov1 = (gate == 0 && b(res_valid_i) == 1 && ne == 1 && head == 1) ? 1 : 0;
      return e;
   endfunction

   task automatic model_check();
      exp_t e;
      e = m_eval();
      chk("hsv_valid", b(hsv_valid_o), e.hv);
      if (e.any != 0) begin
         chk("req0_ready", b(req0_ready_o), e.r0);
         chk("req1_ready", b(req1_ready_o), e.r1);
      end
      chk("res_ready", b(res_ready_o), e.rr);
      chk("out0_valid", b(out0_valid_o), e.ov0);
      chk("out1_valid", b(out1_valid_o), e.ov1);
      if (e.hv != 0) begin
         chk("hsv_mag", hsv_mag_o, (e.g == 1) ? req1_mag_i : req0_mag_i);
         chk("hsv_gx", hsv_gx_o, (e.g == 1) ? req1_gx_i : req0_gx_i);
         chk("hsv_gy", hsv_gy_o, (e.g == 1) ? req1_gy_i : req0_gy_i);
      end
      if (e.ov0 != 0) chk("out0_hv", {out0_h_o, out0_v_o}, {res_h_i, res_v_i});
      if (e.ov1 != 0) chk("out1_hv", {out1_h_o, out1_v_o}, {res_h_i, res_v_i});
   endtask

   task automatic m_update();
      exp_t e;
      e = m_eval();
      if (b(reset_i) == 1) begin
         q.delete();
         m_last = 1;
         m_lock = 0;
         m_lid  = 0;
         m_blk  = 1;
      end else begin
         m_blk = 0;
         if (b(res_valid_i) == 1 && e.rr == 1) void'(q.pop_front());
         if (e.hv == 1 && b(hsv_ready_i) == 1) begin
            q.push_back(e.g);
            m_last = e.g;
         end
         m_lock = (e.hv == 1 && b(hsv_ready_i) == 0) ? 1 : 0;
         if (m_lock == 1) m_lid = e.g;
      end
   endtask

   task automatic set_mag(input logic [7:0] m0, input logic [7:0] m1);
      req0_mag_i = m0;
      req0_gx_i  = m0 ^ 8'h5a;
      req0_gy_i  = m0 + 8'h03;
      req1_mag_i = m1;
      req1_gx_i  = m1 ^ 8'ha5;
      req1_gy_i  = m1 + 8'h07;
   endtask

   task automatic tick();
      #1;
      model_check();
      m_update();
      @(posedge clk_i);
      @(negedge clk_i);
      res_h_i = res_h_i + 8'd1;
      res_v_i = res_v_i + 8'd3;
   endtask

   task automatic idle_inputs();
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      hsv_ready_i  = 1'b0;
      res_valid_i  = 1'b0;
      out0_ready_i = 1'b0;
      out1_ready_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fires;
      reset_i = 1'b1;
      idle_inputs();
      set_mag(8'h00, 8'h00);
      res_h_i = 8'h40;
      res_v_i = 8'h90;
      @(negedge clk_i);

      //         rst v0 v1 hr rv o0 o1 m0     m1     hv r0 r1 rr ov0 ov1 mag
      vt[0]  = '{1, 1, 1, 1, 0, 0, 0, 'h20, 'h30, 0, 0, 0, 0, 0, 0, 'h00};
      vt[1]  = '{0, 1, 0, 1, 0, 0, 0, 'h20, 'h30, 0, 0, 0, 0, 0, 0, 'h00};
      vt[2]  = '{0, 1, 0, 1, 0, 0, 0, 'h20, 'h30, 1, 1, 0, 0, 0, 0, 'h20};
      vt[3]  = '{0, 1, 1, 1, 0, 0, 0, 'h21, 'h30, 1, 0, 1, 0, 0, 0, 'h30};
      vt[4]  = '{0, 1, 1, 1, 0, 0, 0, 'h22, 'h31, 1, 1, 0, 0, 0, 0, 'h22};
      vt[5]  = '{0, 1, 1, 0, 0, 0, 0, 'h23, 'h31, 1, 0, 0, 0, 0, 0, 'h31};
      vt[6]  = '{0, 1, 1, 0, 0, 0, 0, 'h23, 'h31, 1, 0, 0, 0, 0, 0, 'h31};
      vt[7]  = '{0, 1, 1, 1, 0, 0, 0, 'h23, 'h31, 1, 0, 1, 0, 0, 0, 'h31};
      vt[8]  = '{0, 1, 0, 1, 1, 1, 1, 'h24, 'h32, 1, 1, 0, 1, 1, 0, 'h24};
      vt[9]  = '{0, 0, 0, 0, 1, 0, 1, 'h24, 'h32, 0, 0, 0, 1, 0, 1, 'h00};
      vt[10] = '{0, 0, 0, 0, 1, 0, 1, 'h24, 'h32, 0, 0, 0, 0, 1, 0, 'h00};
      vt[11] = '{0, 0, 0, 0, 1, 1, 0, 'h24, 'h32, 0, 0, 0, 1, 1, 0, 'h00};

      for (int i = 0; i < 12; i++) begin
         reset_i      = vt[i].rst[0];
         req0_valid_i = vt[i].v0[0];
         req1_valid_i = vt[i].v1[0];
         hsv_ready_i  = vt[i].hr[0];
         res_valid_i  = vt[i].rv[0];
         out0_ready_i = vt[i].o0r[0];
         out1_ready_i = vt[i].o1r[0];
         set_mag(vt[i].m0[7:0], vt[i].m1[7:0]);
         #1;
         chk($sformatf("vec%0d_hv", i), b(hsv_valid_o), vt[i].hv);
         chk($sformatf("vec%0d_r0", i), b(req0_ready_o), vt[i].r0);
         chk($sformatf("vec%0d_r1", i), b(req1_ready_o), vt[i].r1);
         chk($sformatf("vec%0d_rr", i), b(res_ready_o), vt[i].rr);
         chk($sformatf("vec%0d_ov0", i), b(out0_valid_o), vt[i].ov0);
         chk($sformatf("vec%0d_ov1", i), b(out1_valid_o), vt[i].ov1);
         if (vt[i].hv != 0) chk($sformatf("vec%0d_mag", i), hsv_mag_o, vt[i].mag);
         tick();
      end

      // Alternating issue with continuous drain.
      do_reset();
      req0_valid_i = 1'b1;
      req1_valid_i = 1'b1;
      hsv_ready_i  = 1'b1;
      res_valid_i  = 1'b1;
      out0_ready_i = 1'b1;
      out1_ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_issue", b(req1_ready_o), k % 2);
         if (k > 0) chk("rr_return", b(out1_valid_o), (k - 1) % 2);
         tick();
      end

      // Fill to depth with the head consumer stalled.
      do_reset();
      req0_valid_i = 1'b1;
      hsv_ready_i  = 1'b1;
      res_valid_i  = 1'b1;
      out1_ready_i = 1'b1;
      fires = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (hsv_valid_o && hsv_ready_i) fires++;
         tick();
      end
      chk("full_fires", fires, 8);
      chk("full_hv", b(hsv_valid_o), 0);
      out0_ready_i = 1'b1;
      #1;
      chk("full_pop_rr", b(res_ready_o), 1);
      chk("full_pop_hv", b(hsv_valid_o), 0);
      tick();
      out0_ready_i = 1'b0;
      #1;
      chk("full_ninth_hv", b(hsv_valid_o), 1);
      tick();

      // Head-of-line blocking.
      do_reset();
      req0_valid_i = 1'b1;
      req1_valid_i = 1'b1;
      hsv_ready_i  = 1'b1;
      tick();
      tick();
      idle_inputs();
      res_valid_i  = 1'b1;
      out1_ready_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("hol_rr", b(res_ready_o), 0);
         chk("hol_ov1", b(out1_valid_o), 0);
         chk("hol_ov0", b(out0_valid_o), 1);
         tick();
      end
      out0_ready_i = 1'b1;
      tick();
      out0_ready_i = 1'b0;
      #1;
      chk("hol_after_ov1", b(out1_valid_o), 1);
      chk("hol_after_rr", b(res_ready_o), 1);
      tick();

      // Lock holds channel 1 while channel 0 joins during the stall.
      do_reset();
      req1_valid_i = 1'b1;
      set_mag(8'h11, 8'h44);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) req0_valid_i = 1'b1;
         set_mag(8'h11 + 8'(k), 8'h44);
         #1;
         chk("lock_hv", b(hsv_valid_o), 1);
         chk("lock_mag", hsv_mag_o, 'h44);
         tick();
      end
      hsv_ready_i = 1'b1;
      #1;
      chk("lock_fire_r1", b(req1_ready_o), 1);
      tick();
      #1;
      chk("lock_next_r0", b(req0_ready_o), 1);
      tick();

      // Result with nothing outstanding, then reset with beats in flight.
      do_reset();
      res_valid_i  = 1'b1;
      out0_ready_i = 1'b1;
      out1_ready_i = 1'b1;
      #1;
      chk("empty_rr", b(res_ready_o), 0);
      chk("empty_ov", {b(out0_valid_o), b(out1_valid_o)}, 0);
      tick();
      idle_inputs();
      req0_valid_i = 1'b1;
      hsv_ready_i  = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      do_reset();
      res_valid_i  = 1'b1;
      out0_ready_i = 1'b1;
      out1_ready_i = 1'b1;
      #1;
      chk("midreset_rr", b(res_ready_o), 0);
      tick();

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         reset_i      = ($urandom_range(0, 255) == 0);
         req0_valid_i = $urandom_range(0, 3) != 0;
         req1_valid_i = $urandom_range(0, 3) != 0;
         hsv_ready_i  = $urandom_range(0, 3) != 0;
         res_valid_i  = $urandom_range(0, 2) != 0;
         out0_ready_i = $urandom_range(0, 3) != 0;
         out1_ready_i = $urandom_range(0, 3) != 0;
         set_mag(8'($urandom), 8'($urandom));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
